// File: rtl/reg_path_checker.sv
// Drives LFSR words into a registered data path and checks Q against the delayed words.
// Optional first-mismatch capture ports are enabled with `define CHK_FIRST_FAIL_EN.
module reg_path_checker #(
  parameter int          WIDTH      = 4,
  parameter int          LATENCY    = 1,
  parameter int          NUM_CHECKS = 10,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      pass_cnt,
  output logic [15:0]      fail_cnt
`ifdef CHK_FIRST_FAIL_EN
  ,
  output logic [WIDTH-1:0] first_fail_exp,
  output logic [WIDTH-1:0] first_fail_obs,
  output logic [15:0]      first_fail_idx,
  output logic             first_fail_vld
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                        state_q;
  logic [15:0]                   lfsr_q, lfsr_d;
  logic [LATENCY:0][WIDTH-1:0]   exp_pipe_q, exp_pipe_d;
  logic [LATENCY:0]              vld_pipe_q, vld_pipe_d;
  logic [15:0]                   launch_cnt_q, cmp_idx_q;
  logic [15:0]                   pass_cnt_q, fail_cnt_q;
  logic [WIDTH-1:0]              d_q;
  logic                          busy_q, done_q;
  logic                          launch, cmp_vld, match, last_cmp;
`ifdef CHK_FIRST_FAIL_EN
  logic [WIDTH-1:0]              ff_exp_q, ff_obs_q;
  logic [15:0]                   ff_idx_q;
  logic                          ff_vld_q;
`endif

  assign lfsr_d     = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign launch     = (state_q == RUN);
  assign exp_pipe_d = {exp_pipe_q[LATENCY-1:0], lfsr_q[WIDTH-1:0]};
  assign vld_pipe_d = {vld_pipe_q[LATENCY-1:0], launch};
  assign cmp_vld    = vld_pipe_q[LATENCY];
  assign match      = (q == exp_pipe_q[LATENCY]);
  // Final comparison: the oldest word is valid and nothing younger is in flight.
  assign last_cmp   = cmp_vld && !(|vld_pipe_q[LATENCY-1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      lfsr_q       <= SEED;
      exp_pipe_q   <= '0;
      vld_pipe_q   <= '0;
      launch_cnt_q <= '0;
      cmp_idx_q    <= '0;
      pass_cnt_q   <= '0;
      fail_cnt_q   <= '0;
      d_q          <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef CHK_FIRST_FAIL_EN
      ff_exp_q     <= '0;
      ff_obs_q     <= '0;
      ff_idx_q     <= '0;
      ff_vld_q     <= 1'b0;
`endif
    end else begin
      exp_pipe_q <= exp_pipe_d;
      vld_pipe_q <= vld_pipe_d;
      if (cmp_vld) begin
        cmp_idx_q <= cmp_idx_q + 16'd1;
        if (match) begin
          if (pass_cnt_q != 16'hFFFF) pass_cnt_q <= pass_cnt_q + 16'd1;
        end else begin
          if (fail_cnt_q != 16'hFFFF) fail_cnt_q <= fail_cnt_q + 16'd1;
`ifdef CHK_FIRST_FAIL_EN
          if (!ff_vld_q) begin
            ff_exp_q <= exp_pipe_q[LATENCY];
            ff_obs_q <= q;
            ff_idx_q <= cmp_idx_q;
            ff_vld_q <= 1'b1;
          end
`endif
        end
      end
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q      <= RUN;
            lfsr_q       <= SEED;
            vld_pipe_q   <= '0;
            launch_cnt_q <= '0;
            cmp_idx_q    <= '0;
            pass_cnt_q   <= '0;
            fail_cnt_q   <= '0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
`ifdef CHK_FIRST_FAIL_EN
            ff_exp_q     <= '0;
            ff_obs_q     <= '0;
            ff_idx_q     <= '0;
            ff_vld_q     <= 1'b0;
`endif
          end
        end
        RUN: begin
          d_q          <= lfsr_q[WIDTH-1:0];
          lfsr_q       <= lfsr_d;
          launch_cnt_q <= launch_cnt_q + 16'd1;
          if (launch_cnt_q == 16'(NUM_CHECKS - 1)) state_q <= DRAIN;
        end
        DRAIN: begin
          if (last_cmp) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign d        = d_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = done_q && (fail_cnt_q == 16'd0);
  assign pass_cnt = pass_cnt_q;
  assign fail_cnt = fail_cnt_q;
`ifdef CHK_FIRST_FAIL_EN
  assign first_fail_exp = ff_exp_q;
  assign first_fail_obs = ff_obs_q;
  assign first_fail_idx = ff_idx_q;
  assign first_fail_vld = ff_vld_q;
`endif

endmodule

// File: tb/tb_reg_path_checker.sv
// Four checker instances (default, LATENCY=3, NUM_CHECKS=1, LATENCY=3 on a one-stage path)
// each paired with an emulated register chain and a cycle-indexed reference model.
module tb_reg_path_checker;

  logic       clk = 1'b0;
  logic [3:0] start_s, rst_s;
  logic [3:0] inj [4];
  logic [3:0] d_w [4];
  logic [3:0] q_w [4];
  logic       busy_w [4];
  logic       done_w [4];
  logic       pass_w [4];
  logic [15:0] pc_w [4];
  logic [15:0] fc_w [4];
`ifdef CHK_FIRST_FAIL_EN
  logic [3:0]  ffe_w [4];
  logic [3:0]  ffo_w [4];
  logic [15:0] ffi_w [4];
  logic        ffv_w [4];
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  for (genvar g = 0; g < 4; g++) begin : gi
    localparam int LAT = (g == 1 || g == 3) ? 3 : 1;
    localparam int NCH = (g == 2) ? 1 : 10;
    localparam int DST = (g == 1) ? 3 : 1;

    reg_path_checker #(.WIDTH(4), .LATENCY(LAT), .NUM_CHECKS(NCH), .SEED(16'hACE1)) u_dut (
      .clk(clk), .rst(rst_s[g]), .start(start_s[g]), .d(d_w[g]), .q(q_w[g]),
      .busy(busy_w[g]), .done(done_w[g]), .pass(pass_w[g]),
      .pass_cnt(pc_w[g]), .fail_cnt(fc_w[g])
`ifdef CHK_FIRST_FAIL_EN
      , .first_fail_exp(ffe_w[g]), .first_fail_obs(ffo_w[g]),
      .first_fail_idx(ffi_w[g]), .first_fail_vld(ffv_w[g])
`endif
    );

    // Emulated DUT register path
    logic [3:0] ch [DST];
    initial for (int j = 0; j < DST; j++) ch[j] = 4'h0;
    always @(posedge clk) begin
      ch[0] <= d_w[g];
      for (int j = 1; j < DST; j++) ch[j] <= ch[j-1];
    end
    assign q_w[g] = ch[DST-1] ^ inj[g];

    // Reference model: mk = edges since the accepted start edge (-1 = idle after reset)
    logic [3:0] w [NCH];
    int         mk = -1, mp = 0, mf = 0;
    logic [3:0] md = 4'h0;
    initial begin
      logic [15:0] s;
      s = 16'hACE1;
      for (int i = 0; i < NCH; i++) begin
        w[i] = s[3:0];
        s = lfsr_step(s);
      end
    end

    always @(posedge clk) begin
      int i;
      if (rst_s[g]) begin
        mk = -1; mp = 0; mf = 0; md = 4'h0;
      end else if (start_s[g] && (mk < 0 || mk >= NCH + LAT + 1)) begin
        mk = 0; mp = 0; mf = 0;
      end else if (mk >= 0 && mk < NCH + LAT + 1) begin
        mk++;
        i = mk - 2 - LAT;
        if (i >= 0 && i < NCH) begin
          if (q_w[g] == w[i]) mp++;
          else mf++;
        end
        if (mk >= 1 && mk <= NCH) md = w[mk-1];
      end
    end

    always @(negedge clk) begin
      logic eb, ed;
      eb = (mk >= 0 && mk <= NCH + LAT);
      ed = (mk == NCH + LAT + 1);
      chk($sformatf("g%0d d", g), int'(d_w[g]), int'(md));
      chk($sformatf("g%0d busy", g), int'(busy_w[g]), int'(eb));
      chk($sformatf("g%0d done", g), int'(done_w[g]), int'(ed));
      chk($sformatf("g%0d pass", g), int'(pass_w[g]), int'(ed && mf == 0));
      chk($sformatf("g%0d pass_cnt", g), int'(pc_w[g]), mp);
      chk($sformatf("g%0d fail_cnt", g), int'(fc_w[g]), mf);
    end
  end

  initial begin
    int first_done [4];
    logic [3:0] seq1 [10];
    logic [3:0] seq2 [10];
    start_s = 4'h0;
    rst_s   = 4'hF;
    for (int g = 0; g < 4; g++) inj[g] = 4'h0;
    repeat (3) step();
    chk("reset d", int'(d_w[0]), 0);
    chk("reset busy", int'(busy_w[0]), 0);
    chk("reset done", int'(done_w[0]), 0);
    chk("reset pass", int'(pass_w[0]), 0);
    chk("reset pass_cnt", int'(pc_w[0]), 0);
    chk("reset fail_cnt", int'(fc_w[0]), 0);
    rst_s = 4'h0;
    step();

    // Run 1: all instances, with an ignored second start mid-run on the long ones
    start_s = 4'hF;
    step();
    start_s = 4'h0;
    for (int g = 0; g < 4; g++) first_done[g] = -1;
    for (int c = 0; c <= 30; c++) begin
      if (c >= 1 && c <= 10) seq1[c-1] = d_w[0];
      for (int g = 0; g < 4; g++)
        if (done_w[g] && first_done[g] < 0) first_done[g] = c;
      start_s = (c == 3) ? 4'b1011 : 4'b0000;
      step();
    end
    start_s = 4'h0;
    chk("run1 word0", int'(seq1[0]), 1);
    chk("run1 word1", int'(seq1[1]), 0);
    chk("run1 done cycle g0", first_done[0], 12);
    chk("run1 done cycle lat3", first_done[1], 14);
    chk("run1 done cycle n1", first_done[2], 3);
    chk("run1 pass_cnt g0", int'(pc_w[0]), 10);
    chk("run1 fail_cnt g0", int'(fc_w[0]), 0);
    chk("run1 pass g0", int'(pass_w[0]), 1);
    chk("run1 pass_cnt lat3", int'(pc_w[1]), 10);
    chk("run1 pass_cnt n1", int'(pc_w[2]), 1);
    chk("run1 lat3 on 1-stage fails", int'(fc_w[3] != 16'd0), 1);

    // Run 2: rerun g0 with q inverted during the comparison of word 2
    start_s = 4'b0001;
    step();
    start_s = 4'h0;
    for (int c = 0; c <= 15; c++) begin
      if (c >= 1 && c <= 10) seq2[c-1] = d_w[0];
      inj[0] = (c == 4) ? 4'hF : 4'h0;
      step();
    end
    inj[0] = 4'h0;
    for (int i = 0; i < 10; i++) chk($sformatf("rerun word%0d", i), int'(seq2[i]), int'(seq1[i]));
    chk("run2 fail_cnt", int'(fc_w[0]), 1);
    chk("run2 pass_cnt", int'(pc_w[0]), 9);
    chk("run2 pass", int'(pass_w[0]), 0);
`ifdef CHK_FIRST_FAIL_EN
    chk("ff vld", int'(ffv_w[0]), 1);
    chk("ff idx", int'(ffi_w[0]), 2);
    chk("ff exp", int'(ffe_w[0]), 8);
    chk("ff obs", int'(ffo_w[0]), 7);
`endif

    // Run 3: reset in the middle of RUN
    start_s = 4'b0001;
    step();
    start_s = 4'h0;
    repeat (4) step();
    rst_s = 4'b0001;
    step();
    rst_s = 4'h0;
    chk("midrst busy", int'(busy_w[0]), 0);
    chk("midrst d", int'(d_w[0]), 0);
    chk("midrst pass_cnt", int'(pc_w[0]), 0);
    chk("midrst fail_cnt", int'(fc_w[0]), 0);
    repeat (6) step();
    chk("idle pass_cnt", int'(pc_w[0]), 0);
    chk("idle busy", int'(busy_w[0]), 0);

    // Random starts, resets and q corruption, checked by the models
    repeat (600) begin
      for (int g = 0; g < 4; g++) begin
        start_s[g] = ($urandom_range(7) == 0);
        rst_s[g]   = ($urandom_range(63) == 0);
        inj[g]     = ($urandom_range(5) == 0) ? 4'($urandom_range(15)) : 4'h0;
      end
      step();
    end
    start_s = 4'h0;
    rst_s   = 4'h0;
    for (int g = 0; g < 4; g++) inj[g] = 4'h0;
    repeat (30) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
